// File: rtl/operand_entry_if.sv
// Keypad-to-operand bundle: keystroke strobe in, committed/live operand out.
// operand_entry drives the outputs through the master modport; the keypad/bench uses slave.
interface operand_entry_if;
  logic       key_valid;
  logic [4:0] key_code;
  logic [8:0] op1;
  logic       enter;
  logic [8:0] entry_val;
  logic [1:0] digit_count;
  logic       neg;
  logic       err;

  modport master (
    input  key_valid, key_code,
    output op1, enter, entry_val, digit_count, neg, err
  );

  modport slave (
    output key_valid, key_code,
    input  op1, enter, entry_val, digit_count, neg, err
  );
endinterface

// File: rtl/operand_entry.sv
// Collects decimal keystrokes into a signed 9-bit operand (-256..+255) held as
// three BCD digits plus a sign, and commits it on op1 with a one-cycle enter strobe.
module operand_entry (
  input  logic             clk,
  input  logic             nrst,
  operand_entry_if.master  bus
);

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_COMMIT} state_t;

  localparam logic [4:0] K_NEG   = 5'd10;
  localparam logic [4:0] K_BKSP  = 5'd11;
  localparam logic [4:0] K_CLR   = 5'd12;
  localparam logic [4:0] K_ENTER = 5'd13;

  state_t     r_state, w_state_nx;
  logic [3:0] r_d2, r_d1, r_d0;
  logic [3:0] w_d2_nx, w_d1_nx, w_d0_nx;
  logic [1:0] r_count, w_count_nx;
  logic       r_neg, w_neg_nx;
  logic [8:0] r_op1, w_op1_nx;
  logic       r_enter, w_enter_nx;
  logic       r_err, w_err_nx;

  logic [9:0]  w_mag;
  logic [11:0] w_cand;
  logic [11:0] w_limit;
  logic [8:0]  w_entry_val;
  logic        w_neg_locked;

  // The digit registers never hold a magnitude above the active limit, so the
  // 9-bit two's-complement view of +/-mag is always exact.
  always_comb begin
    w_mag        = 10'(r_d2) * 10'd100 + 10'(r_d1) * 10'd10 + 10'(r_d0);
    w_cand       = 12'(w_mag) * 12'd10 + 12'(bus.key_code[3:0]);
    w_limit      = r_neg ? 12'd256 : 12'd255;
    w_entry_val  = r_neg ? 9'(10'd0 - w_mag) : w_mag[8:0];
    w_neg_locked = r_neg && (w_mag == 10'd256);
  end

  // NOTE: every next-state signal takes a default before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    w_d2_nx    = r_d2;
    w_d1_nx    = r_d1;
    w_d0_nx    = r_d0;
    w_count_nx = r_count;
    w_neg_nx   = r_neg;
    w_op1_nx   = r_op1;
    w_enter_nx = 1'b0;
    w_err_nx   = 1'b0;

    if (r_state == S_COMMIT) begin
      w_state_nx = S_EMPTY;
      w_d2_nx    = 4'd0;
      w_d1_nx    = 4'd0;
      w_d0_nx    = 4'd0;
      w_count_nx = 2'd0;
      w_neg_nx   = 1'b0;
      w_err_nx   = bus.key_valid;
    end else if (bus.key_valid) begin
      if (bus.key_code < 5'd10) begin
        if (r_count < 2'd3 && w_cand <= w_limit) begin
          w_d2_nx    = r_d1;
          w_d1_nx    = r_d0;
          w_d0_nx    = bus.key_code[3:0];
          w_count_nx = r_count + 2'd1;
          w_state_nx = S_ENTRY;
        end else begin
          w_err_nx = 1'b1;
        end
      end else begin
        case (bus.key_code)
          K_NEG: begin
            if (w_neg_locked) w_err_nx = 1'b1;
            else              w_neg_nx = ~r_neg;
          end
          K_BKSP: begin
            if (r_state == S_ENTRY) begin
              w_d0_nx    = r_d1;
              w_d1_nx    = r_d2;
              w_d2_nx    = 4'd0;
              w_count_nx = r_count - 2'd1;
              if (r_count == 2'd1) w_state_nx = S_EMPTY;
            end else begin
              w_neg_nx = 1'b0;
            end
          end
          K_CLR: begin
            w_d2_nx    = 4'd0;
            w_d1_nx    = 4'd0;
            w_d0_nx    = 4'd0;
            w_count_nx = 2'd0;
            w_neg_nx   = 1'b0;
            w_state_nx = S_EMPTY;
          end
          K_ENTER: begin
            if (r_state == S_ENTRY) begin
              w_op1_nx   = w_entry_val;
              w_enter_nx = 1'b1;
              w_state_nx = S_COMMIT;
            end else begin
              w_err_nx = 1'b1;
            end
          end
          default: w_err_nx = 1'b1;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and an asynchronous
  // active-low reset, which also aborts an in-flight enter pulse at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_EMPTY;
      r_d2    <= 4'd0;
      r_d1    <= 4'd0;
      r_d0    <= 4'd0;
      r_count <= 2'd0;
      r_neg   <= 1'b0;
      r_op1   <= 9'd0;
      r_enter <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_d2    <= w_d2_nx;
      r_d1    <= w_d1_nx;
      r_d0    <= w_d0_nx;
      r_count <= w_count_nx;
      r_neg   <= w_neg_nx;
      r_op1   <= w_op1_nx;
      r_enter <= w_enter_nx;
      r_err   <= w_err_nx;
    end
  end

  assign bus.op1         = r_op1;
  assign bus.enter       = r_enter;
  assign bus.err         = r_err;
  assign bus.entry_val   = w_entry_val;
  assign bus.digit_count = r_count;
  assign bus.neg         = r_neg;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry: keystrokes applied on falling edges,
// outputs checked on the following falling edge against hand-computed values.
module tb_operand_entry;

  logic clk;
  logic nrst;
  int   checks   = 0;
  int   failures = 0;

  operand_entry_if bus ();

  operand_entry dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: the key is sampled at the next rising edge and
  // the call returns at the falling edge after it, where the result is visible.
  task automatic key(input logic [4:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    nrst          = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    #12;
    check("rst_op1",   32'(bus.op1), 32'h0);
    check("rst_enter", 32'(bus.enter), 32'h0);
    check("rst_err",   32'(bus.err), 32'h0);
    check("rst_val",   32'(bus.entry_val), 32'h0);
    check("rst_cnt",   32'(bus.digit_count), 32'h0);
    check("rst_neg",   32'(bus.neg), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    idle();

    // 1,2,3,ENTER
    key(5'd1);  check("t1_val1", 32'(bus.entry_val), 32'd1);
    key(5'd2);  check("t1_val12", 32'(bus.entry_val), 32'd12);
    key(5'd3);  check("t1_val123", 32'(bus.entry_val), 32'd123);
    key(5'd13);
    check("t1_enter_hi", 32'(bus.enter), 32'h1);
    check("t1_op1", 32'(bus.op1), 32'd123);
    check("t1_err_lo", 32'(bus.err), 32'h0);
    idle();
    check("t1_enter_lo", 32'(bus.enter), 32'h0);
    check("t1_cnt0", 32'(bus.digit_count), 32'h0);
    check("t1_val0", 32'(bus.entry_val), 32'h0);
    check("t1_op1_hold", 32'(bus.op1), 32'd123);

    // NEG,2,5,6 -> -256; NEG rejected at the limit; ENTER commits -256
    key(5'd10); check("t2_neg1", 32'(bus.neg), 32'h1);
    key(5'd2);  check("t2_val_m2", 32'(bus.entry_val), 32'h1FE);
    key(5'd5);
    key(5'd6);  check("t2_val_m256", 32'(bus.entry_val), 32'h100);
    key(5'd10);
    check("t2_neg_err", 32'(bus.err), 32'h1);
    check("t2_neg_kept", 32'(bus.neg), 32'h1);
    key(5'd13);
    check("t2_err_fall", 32'(bus.err), 32'h0);
    check("t2_op1", 32'(bus.op1), 32'h100);
    check("t2_enter", 32'(bus.enter), 32'h1);
    idle();
    check("t2_neg_clr", 32'(bus.neg), 32'h0);
    key(5'd2);
    key(5'd5);
    key(5'd6);
    check("t2_pos_lim_err", 32'(bus.err), 32'h1);
    check("t2_pos_val", 32'(bus.entry_val), 32'd25);
    check("t2_pos_cnt", 32'(bus.digit_count), 32'd2);
    key(5'd12);

    // 9,9,BKSP x3
    key(5'd9);  check("t3_val9", 32'(bus.entry_val), 32'd9);
    key(5'd9);  check("t3_val99", 32'(bus.entry_val), 32'd99);
    key(5'd11); check("t3_bk9", 32'(bus.entry_val), 32'd9);
    key(5'd11);
    check("t3_bk0", 32'(bus.entry_val), 32'd0);
    check("t3_cnt0", 32'(bus.digit_count), 32'd0);
    key(5'd11); check("t3_bk_empty_noerr", 32'(bus.err), 32'h0);
    // backspace to empty keeps the sign; backspace in empty clears it
    key(5'd10);
    key(5'd5);  check("t3_val_m5", 32'(bus.entry_val), 32'h1FB);
    key(5'd11);
    check("t3_sign_kept", 32'(bus.neg), 32'h1);
    check("t3_cnt_back0", 32'(bus.digit_count), 32'd0);
    key(5'd11);
    check("t3_sign_clr", 32'(bus.neg), 32'h0);
    check("t3_sign_noerr", 32'(bus.err), 32'h0);

    // ENTER in EMPTY
    key(5'd13);
    check("t4_empty_err", 32'(bus.err), 32'h1);
    check("t4_empty_noenter", 32'(bus.enter), 32'h0);
    check("t4_op1_same", 32'(bus.op1), 32'h100);

    // leading zero counts as a digit; fourth digit rejected
    key(5'd0);
    check("t5_zero_cnt", 32'(bus.digit_count), 32'd1);
    check("t5_zero_noerr", 32'(bus.err), 32'h0);
    key(5'd1);
    key(5'd2);
    check("t5_val12", 32'(bus.entry_val), 32'd12);
    check("t5_cnt3", 32'(bus.digit_count), 32'd3);
    key(5'd3);
    check("t5_full_err", 32'(bus.err), 32'h1);
    check("t5_full_val", 32'(bus.entry_val), 32'd12);
    key(5'd12);

    // 4,2, invalid code, CLR
    key(5'd4);
    key(5'd2);
    key(5'd20);
    check("t6_inv_err", 32'(bus.err), 32'h1);
    check("t6_inv_val", 32'(bus.entry_val), 32'd42);
    check("t6_inv_cnt", 32'(bus.digit_count), 32'd2);
    key(5'd12);
    check("t6_clr_val", 32'(bus.entry_val), 32'd0);
    check("t6_clr_cnt", 32'(bus.digit_count), 32'd0);
    check("t6_clr_op1", 32'(bus.op1), 32'h100);

    // key arriving while enter is high is dropped with err
    key(5'd7);
    key(5'd13);
    check("t7_enter", 32'(bus.enter), 32'h1);
    check("t7_op1", 32'(bus.op1), 32'd7);
    key(5'd5);
    check("t7_drop_err", 32'(bus.err), 32'h1);
    check("t7_drop_enter", 32'(bus.enter), 32'h0);
    check("t7_drop_cnt", 32'(bus.digit_count), 32'd0);
    check("t7_drop_val", 32'(bus.entry_val), 32'd0);
    idle();
    check("t7_err_1cyc", 32'(bus.err), 32'h0);

    // reset during the commit cycle
    key(5'd7);
    key(5'd13);
    check("t8_enter_pre", 32'(bus.enter), 32'h1);
    nrst = 1'b0;
    #1;
    check("t8_enter_abort", 32'(bus.enter), 32'h0);
    check("t8_op1_rst", 32'(bus.op1), 32'h0);
    check("t8_val_rst", 32'(bus.entry_val), 32'h0);
    check("t8_cnt_rst", 32'(bus.digit_count), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    key(5'd3);
    check("t8_after_rst", 32'(bus.entry_val), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
